// File: rtl/predictor_pkg.sv
// Shared types and constants for the local 2-bit branch pattern table controller.
package predictor_pkg;

  typedef enum logic [1:0] {INIT, IDLE, UPD_RD, UPD_WR} state_t;

  localparam logic [1:0] WEAK_NT = 2'b01;
  localparam logic [1:0] SAT_MAX = 2'b11;
  localparam logic [1:0] SAT_MIN = 2'b00;

  function automatic logic [1:0] sat_update(input logic [1:0] cur, input logic taken);
    if (taken) return (cur == SAT_MAX) ? SAT_MAX : cur + 2'd1;
    else       return (cur == SAT_MIN) ? SAT_MIN : cur - 2'd1;
  endfunction

endpackage

// File: rtl/predictor_update_fifo.sv
// Training-update FIFO; full/empty derived from an occupancy count, pointers wrap modulo DEPTH.
module predictor_update_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 13
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic             do_push;
  logic             do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/predictor_ctrl.sv
// Single-port branch pattern table controller: init sweep, lookup/RMW-update arbitration, prediction.
// Optional PREDICTOR_STATS_EN builds lookup/update/forced-grant counters behind the stat* ports.
module predictor_ctrl
  import predictor_pkg::*;
#(
  parameter int LOCAL_WIDTH  = 12,
  parameter int UPD_DEPTH    = 4,
  parameter int STARVE_LIMIT = 8
) (
  input  logic                   clockIn,
  input  logic                   resetIn,
  input  logic                   lookupValid,
  input  logic [31:0]            lookupAddr,
  output logic                   lookupReady,
  output logic                   jumpValid,
  output logic                   jump,
  input  logic                   updateValid,
  input  logic [31:0]            updateAddr,
  input  logic                   taken,
  output logic                   updateReady,
  output logic                   initDone,
  output logic                   tableEn,
  output logic                   tableWe,
  output logic [LOCAL_WIDTH-1:0] tableIdx,
  output logic [1:0]             tableWData,
  input  logic [1:0]             tableRData,
  output logic [31:0]            statLookups,
  output logic [31:0]            statUpdates,
  output logic [31:0]            statForced
);

  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam int EW = LOCAL_WIDTH + 1;
  localparam logic [LOCAL_WIDTH-1:0] LAST_IDX = '1;

  state_t                 state, state_nxt;
  logic [LOCAL_WIDTH-1:0] sweep_idx;
  logic [SW-1:0]          starve_cnt;
  logic                   starve_hit;
  logic                   init_done_r;
  logic                   jump_vld_p1;
  logic                   jump_hold;
  logic [1:0]             rdata_p1;
  logic [LOCAL_WIDTH-1:0] lk_idx;
  logic [EW-1:0]          head;
  logic                   fifo_full, fifo_empty, fifo_push, fifo_pop;
  logic                   upd_grant, lk_grant;
  logic                   unused_addr;

  assign lk_idx      = lookupAddr[LOCAL_WIDTH+1:2];
  assign starve_hit  = (starve_cnt == SW'(STARVE_LIMIT));
  assign fifo_push   = updateValid && !fifo_full;
  assign updateReady = !fifo_full;
  assign initDone    = init_done_r;
  assign jumpValid   = jump_vld_p1;
  assign jump        = jump_vld_p1 ? (tableRData > WEAK_NT) : jump_hold;
  assign unused_addr = ^{lookupAddr[31:LOCAL_WIDTH+2], lookupAddr[1:0],
                         updateAddr[31:LOCAL_WIDTH+2], updateAddr[1:0]};

  predictor_update_fifo #(
    .DEPTH (UPD_DEPTH),
    .WIDTH (EW)
  ) u_fifo (
    .clk   (clockIn),
    .rst   (resetIn),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .wdata ({updateAddr[LOCAL_WIDTH+1:2], taken}),
    .rdata (head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_comb begin
    state_nxt   = state;
    tableEn     = 1'b0;
    tableWe     = 1'b0;
    tableIdx    = '0;
    tableWData  = '0;
    lookupReady = 1'b0;
    upd_grant   = 1'b0;
    lk_grant    = 1'b0;
    fifo_pop    = 1'b0;
    case (state)
      INIT: begin
        tableEn    = 1'b1;
        tableWe    = 1'b1;
        tableIdx   = sweep_idx;
        tableWData = WEAK_NT;
        if (sweep_idx == LAST_IDX) state_nxt = IDLE;
      end
      IDLE: begin
        if (!fifo_empty && (!lookupValid || starve_hit)) begin
          upd_grant = 1'b1;
          tableEn   = 1'b1;
          tableIdx  = head[EW-1:1];
          state_nxt = UPD_RD;
        end else begin
          lookupReady = 1'b1;
          if (lookupValid) begin
            lk_grant = 1'b1;
            tableEn  = 1'b1;
            tableIdx = lk_idx;
          end
        end
      end
      UPD_RD: state_nxt = UPD_WR;
      UPD_WR: begin
        tableEn    = 1'b1;
        tableWe    = 1'b1;
        tableIdx   = head[EW-1:1];
        tableWData = sat_update(rdata_p1, head[0]);
        fifo_pop   = 1'b1;
        state_nxt  = IDLE;
      end
      default: state_nxt = INIT;
    endcase
    // Reset parks in INIT; keep the RAM port quiet until reset is released.
    if (resetIn) begin
      tableEn = 1'b0;
      tableWe = 1'b0;
    end
  end

  always_ff @(posedge clockIn or posedge resetIn) begin
    if (resetIn) begin
      state       <= INIT;
      sweep_idx   <= '0;
      starve_cnt  <= '0;
      init_done_r <= 1'b0;
      jump_vld_p1 <= 1'b0;
      jump_hold   <= 1'b0;
    end else begin
      state       <= state_nxt;
      jump_vld_p1 <= lk_grant;
      if (state == INIT) sweep_idx <= sweep_idx + LOCAL_WIDTH'(1);
      if (state == INIT && sweep_idx == LAST_IDX) init_done_r <= 1'b1;
      if (upd_grant) starve_cnt <= '0;
      else if (lk_grant) begin
        if (fifo_empty)      starve_cnt <= '0;
        else if (!starve_hit) starve_cnt <= starve_cnt + SW'(1);
      end
      if (jump_vld_p1) jump_hold <= (tableRData > WEAK_NT);
    end
  end

  // p1: table read data captured in UPD_RD for the UPD_WR modify
  always_ff @(posedge clockIn) begin
    if (state == UPD_RD) rdata_p1 <= tableRData;
  end

`ifdef PREDICTOR_STATS_EN
  logic [31:0] lookups_cnt, updates_cnt, forced_cnt;

  always_ff @(posedge clockIn or posedge resetIn) begin
    if (resetIn) begin
      lookups_cnt <= '0;
      updates_cnt <= '0;
      forced_cnt  <= '0;
    end else begin
      if (lk_grant)                 lookups_cnt <= lookups_cnt + 32'd1;
      if (state == UPD_WR)          updates_cnt <= updates_cnt + 32'd1;
      if (upd_grant && lookupValid) forced_cnt  <= forced_cnt + 32'd1;
    end
  end

  assign statLookups = lookups_cnt;
  assign statUpdates = updates_cnt;
  assign statForced  = forced_cnt;
`else
  assign statLookups = '0;
  assign statUpdates = '0;
  assign statForced  = '0;
`endif

endmodule

// File: tb/tb_predictor_ctrl.sv
// Scoreboard bench for predictor_ctrl with LOCAL_WIDTH=4, UPD_DEPTH=4, STARVE_LIMIT=8.
module tb_predictor_ctrl;

  localparam int LW   = 4;
  localparam int DEP  = 4;
  localparam int SLIM = 8;
  localparam int N    = 16;

  logic          clockIn = 1'b0;
  logic          resetIn = 1'b0;
  logic          lookupValid = 1'b0;
  logic [31:0]   lookupAddr = '0;
  logic          lookupReady, jumpValid, jump;
  logic          updateValid = 1'b0;
  logic [31:0]   updateAddr = '0;
  logic          taken = 1'b0;
  logic          updateReady, initDone, tableEn, tableWe;
  logic [LW-1:0] tableIdx;
  logic [1:0]    tableWData;
  logic [1:0]    ram_q;
  logic [31:0]   statLookups, statUpdates, statForced;

  always #5 clockIn = ~clockIn;

  predictor_ctrl #(.LOCAL_WIDTH(LW), .UPD_DEPTH(DEP), .STARVE_LIMIT(SLIM)) dut (
    .clockIn(clockIn), .resetIn(resetIn),
    .lookupValid(lookupValid), .lookupAddr(lookupAddr), .lookupReady(lookupReady),
    .jumpValid(jumpValid), .jump(jump),
    .updateValid(updateValid), .updateAddr(updateAddr), .taken(taken),
    .updateReady(updateReady), .initDone(initDone),
    .tableEn(tableEn), .tableWe(tableWe), .tableIdx(tableIdx),
    .tableWData(tableWData), .tableRData(ram_q),
    .statLookups(statLookups), .statUpdates(statUpdates), .statForced(statForced)
  );

  // Single-port synchronous RAM model; read data holds until the next read.
  logic [1:0] ram [N];
  always @(posedge clockIn) begin
    if (tableEn) begin
      if (tableWe) ram[tableIdx] <= tableWData;
      else         ram_q <= ram[tableIdx];
    end
  end

  int            asserts = 0;
  int            fails = 0;
  logic [1:0]    ref_mem [N];
  logic [LW+1:0] exp_wr_q [$];
  logic          exp_jump_q [$];
  bit            lk_acc, up_acc, rd_seen, stim_ok;

  function automatic logic [1:0] model_next(input logic [1:0] v, input logic t);
    int x;
    x = int'(v) + (t ? 1 : -1);
    if (x > 3) x = 3;
    if (x < 0) x = 0;
    return 2'(x);
  endfunction

  // One clock: record accepted transactions into the scoreboard, then advance to drive time.
  task automatic step();
    logic [LW-1:0] ix;
    logic [1:0]    nv;
    @(negedge clockIn);
    lk_acc  = lookupValid && lookupReady;
    up_acc  = updateValid && updateReady;
    rd_seen = initDone && tableEn && !tableWe && !lookupReady;
    if (lk_acc) exp_jump_q.push_back(ref_mem[lookupAddr[LW+1:2]] > 2'b01);
    if (up_acc) begin
      ix = updateAddr[LW+1:2];
      nv = model_next(ref_mem[ix], taken);
      ref_mem[ix] = nv;
      exp_wr_q.push_back({ix, nv});
    end
    @(posedge clockIn);
    #1;
  endtask

  task automatic do_update(input logic [31:0] a, input logic t);
    int n = 0;
    updateValid = 1'b1; updateAddr = a; taken = t;
    do begin step(); n++; end while (!up_acc && n < 200);
    updateValid = 1'b0;
    if (!up_acc) stim_ok = 1'b0;
  endtask

  task automatic do_lookup(input logic [31:0] a);
    int n = 0;
    lookupValid = 1'b1; lookupAddr = a;
    do begin step(); n++; end while (!lk_acc && n < 200);
    lookupValid = 1'b0;
    if (!lk_acc) stim_ok = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while ((exp_wr_q.size() != 0 || exp_jump_q.size() != 0) && n < 200) begin step(); n++; end
    if (n >= 200) stim_ok = 1'b0;
  endtask

  // Scoreboard side: predictions, RMW writes and the RMW port-occupancy shape.
  int            rmw_phase = 0;
  logic          mon_e;
  logic [LW+1:0] mon_w;
  always begin
    @(negedge clockIn);
    #1;
    if (resetIn) rmw_phase = 0;
    else begin
      if (jumpValid) begin
        asserts++;
        if (exp_jump_q.size() == 0) begin
          fails++; $display("FAIL jump_extra: jumpValid=1 jump=%b, no lookup outstanding", jump);
        end else begin
          mon_e = exp_jump_q.pop_front();
          if (jump !== mon_e) begin fails++; $display("FAIL jump: got %b expected %b", jump, mon_e); end
        end
      end
      if (rmw_phase == 1) begin
        asserts++;
        if (tableEn !== 1'b0 || lookupReady !== 1'b0) begin
          fails++; $display("FAIL upd_rd_idle: tableEn=%b lookupReady=%b expected 0 0", tableEn, lookupReady);
        end
        rmw_phase = 2;
      end else if (rmw_phase == 2) begin
        asserts++;
        if (tableWe !== 1'b1 || lookupReady !== 1'b0) begin
          fails++; $display("FAIL upd_wr_slot: tableWe=%b lookupReady=%b expected 1 0", tableWe, lookupReady);
        end
        rmw_phase = 0;
      end
      if (initDone && tableEn && tableWe) begin
        asserts++;
        if (exp_wr_q.size() == 0) begin
          fails++; $display("FAIL write_extra: idx=%0d data=%0d, no update outstanding", tableIdx, tableWData);
        end else begin
          mon_w = exp_wr_q.pop_front();
          if ({tableIdx, tableWData} !== mon_w) begin
            fails++; $display("FAIL write: got idx=%0d data=%0d expected idx=%0d data=%0d",
                              tableIdx, tableWData, mon_w[LW+1:2], mon_w[1:0]);
          end
        end
      end
      if (initDone && tableEn && !tableWe && !lookupReady) rmw_phase = 1;
    end
  end

  task automatic test_reset();
    #1 resetIn = 1'b1;
    @(posedge clockIn); @(posedge clockIn); #1;
    asserts++;
    if ({lookupReady, jumpValid, jump, initDone, tableEn, tableWe, updateReady} !== 7'b0000001) begin
      fails++; $display("FAIL reset_outputs: got %b expected 0000001",
                        {lookupReady, jumpValid, jump, initDone, tableEn, tableWe, updateReady});
    end
    resetIn = 1'b0;
    for (int i = 0; i < N; i++) begin
      @(negedge clockIn);
      asserts++;
      if (!(tableEn === 1'b1 && tableWe === 1'b1 && tableIdx === LW'(i) && tableWData === 2'b01
            && initDone === 1'b0 && lookupReady === 1'b0)) begin
        fails++; $display("FAIL sweep_%0d: en=%b we=%b idx=%0d data=%0d done=%b expected 1 1 %0d 1 0",
                          i, tableEn, tableWe, tableIdx, tableWData, initDone, i);
      end
    end
    @(negedge clockIn);
    asserts++;
    if (initDone !== 1'b1) begin fails++; $display("FAIL init_done: got %b expected 1", initDone); end
    @(posedge clockIn); #1;
    for (int i = 0; i < N; i++) ref_mem[i] = 2'b01;
    stim_ok = 1'b1;
    do_lookup(32'h0);
    drain();
    asserts++;
    if (!stim_ok) begin fails++; $display("FAIL reset_lookup: stimulus timed out, got 0 expected 1"); end
  endtask

  task automatic test_update_basic();
    stim_ok = 1'b1;
    do_update(32'h8, 1'b1); drain();
    asserts++;
    if (ram[2] !== 2'd2) begin fails++; $display("FAIL taken_once: ram[2]=%0d expected 2", ram[2]); end
    do_lookup(32'h8); drain();
    for (int k = 0; k < 4; k++) do_update(32'h8, 1'b0);
    drain();
    asserts++;
    if (ram[2] !== 2'd0) begin fails++; $display("FAIL sat_low: ram[2]=%0d expected 0", ram[2]); end
    do_lookup(32'h8); drain();
    do_update(32'h8, 1'b0); drain();
    asserts++;
    if (ram[2] !== 2'd0 || !stim_ok) begin
      fails++; $display("FAIL sat_low_again: ram[2]=%0d ok=%b expected 0 1", ram[2], stim_ok);
    end
  endtask

  task automatic test_saturate_up();
    int n = 0;
    stim_ok = 1'b1;
    lookupValid = 1'b1; lookupAddr = 32'h0;
    for (int k = 0; k < 3; k++) do_update(32'hC, 1'b1);
    while (exp_wr_q.size() != 0 && n < 200) begin step(); n++; end
    lookupValid = 1'b0;
    drain();
    asserts++;
    if (ram[3] !== 2'd3 || !stim_ok || n >= 200) begin
      fails++; $display("FAIL sat_high: ram[3]=%0d ok=%b expected 3 1", ram[3], stim_ok);
    end
  endtask

  task automatic test_starvation();
    logic pat [5] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
    int   grants = 0;
    int   n = 0;
    bit   first_rd = 1'b0;
    bit   pushed5 = 1'b0;
    stim_ok = 1'b1;
    lookupValid = 1'b1; lookupAddr = 32'h0;
    do_update(32'h14, pat[0]);
    for (int k = 1; k < 4; k++) begin
      do_update(32'h14, pat[k]);
      if (lk_acc) grants++;
    end
    asserts++;
    if (updateReady !== 1'b0) begin fails++; $display("FAIL fifo_full: updateReady=%b expected 0", updateReady); end
    updateValid = 1'b1; updateAddr = 32'h14; taken = pat[4];
    while (!(pushed5 && first_rd) && n < 300) begin
      step(); n++;
      if (lk_acc && !first_rd) grants++;
      if (rd_seen && !first_rd) begin
        first_rd = 1'b1;
        asserts++;
        if (grants != SLIM) begin fails++; $display("FAIL starve_grants: got %0d expected %0d", grants, SLIM); end
      end
      if (up_acc) begin
        updateValid = 1'b0; pushed5 = 1'b1;
        asserts++;
        if (!first_rd) begin fails++; $display("FAIL fifth_push: accepted before first pop, got 1 expected 0"); end
      end
    end
    updateValid = 1'b0;
    n = 0;
    while (exp_wr_q.size() != 0 && n < 300) begin step(); n++; end
    lookupValid = 1'b0;
    drain();
    asserts++;
    if (ram[5] !== 2'd3 || !stim_ok || !pushed5) begin
      fails++; $display("FAIL starve_applied: ram[5]=%0d pushed5=%b expected 3 1", ram[5], pushed5);
    end
    asserts++;
`ifdef PREDICTOR_STATS_EN
    if (statForced !== 32'd8) begin fails++; $display("FAIL stat_forced: got %0d expected 8", statForced); end
`else
    if (statForced !== 32'd0) begin fails++; $display("FAIL stat_forced: got %0d expected 0", statForced); end
`endif
  endtask

  task automatic test_reset_mid();
    int n = 0;
    stim_ok = 1'b1;
    do_update(32'h4, 1'b1);
    do begin step(); n++; end while (!rd_seen && n < 50);
    @(posedge clockIn); #1;
    asserts++;
    if (tableWe !== 1'b1 || n >= 50) begin fails++; $display("FAIL reach_upd_wr: tableWe=%b expected 1", tableWe); end
    resetIn = 1'b1;
    #1;
    asserts++;
    if ({tableEn, tableWe, updateReady, initDone, jumpValid} !== 5'b00100) begin
      fails++; $display("FAIL mid_reset: en/we/ready/done/jv=%b expected 00100",
                        {tableEn, tableWe, updateReady, initDone, jumpValid});
    end
    exp_wr_q.delete(); exp_jump_q.delete();
    for (int i = 0; i < N; i++) ref_mem[i] = 2'b01;
    @(posedge clockIn); #1;
    asserts++;
    if (ram[1] !== 2'b01) begin fails++; $display("FAIL rmw_aborted: ram[1]=%0d expected 1", ram[1]); end
    resetIn = 1'b0;
    @(negedge clockIn);
    asserts++;
    if (!(tableEn === 1'b1 && tableWe === 1'b1 && tableIdx === '0 && tableWData === 2'b01)) begin
      fails++; $display("FAIL sweep_restart: en=%b we=%b idx=%0d data=%0d expected 1 1 0 1",
                        tableEn, tableWe, tableIdx, tableWData);
    end
    repeat (N) @(negedge clockIn);
    asserts++;
    if (initDone !== 1'b1 || tableEn !== 1'b0) begin
      fails++; $display("FAIL resweep_done: initDone=%b tableEn=%b expected 1 0", initDone, tableEn);
    end
    @(posedge clockIn); #1;
    n = 0;
    for (int k = 0; k < 4; k++) begin step(); if (rd_seen) n++; end
    asserts++;
    if (n != 0) begin fails++; $display("FAIL fifo_flushed: %0d update reads expected 0", n); end
  endtask

  task automatic test_stats();
    stim_ok = 1'b1;
    for (int k = 0; k < 10; k++) do_lookup(32'h0);
    do_update(32'h1C, 1'b1); do_update(32'h1C, 1'b1); do_update(32'h1C, 1'b0);
    drain();
    asserts++;
    if (ram[7] !== 2'd2 || !stim_ok) begin fails++; $display("FAIL stats_traffic: ram[7]=%0d ok=%b expected 2 1", ram[7], stim_ok); end
    asserts++;
`ifdef PREDICTOR_STATS_EN
    if ({statLookups, statUpdates, statForced} !== {32'd10, 32'd3, 32'd0}) begin
      fails++; $display("FAIL stats: lookups=%0d updates=%0d forced=%0d expected 10 3 0",
                        statLookups, statUpdates, statForced);
    end
`else
    if ({statLookups, statUpdates, statForced} !== 96'd0) begin
      fails++; $display("FAIL stats: lookups=%0d updates=%0d forced=%0d expected 0 0 0",
                        statLookups, statUpdates, statForced);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_update_basic();
    test_saturate_up();
    test_starvation();
    test_reset_mid();
    test_stats();
    $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
